input_spike_scheduler: RTL and testbench

Controller for a bank of input neurons. It generates the shared timer_en tick that paces every neuron's period counter. It round-robin arbitrates the neurons' held-high spike flags and serialises them as addressed events on a valid/ready stream to the downstream synapse layer. It returns a one-cycle ack_in pulse to the neuron whose event was accepted. It sits between the input neuron array and the first layer's event input.

---
 rtl/snn_ctrl_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/input_spike_scheduler.sv | 128 ++++++++++++
 tb/tb_input_spike_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_ctrl_pkg
// Brief   : Shared types, defaults and helpers for SNN control blocks.
// Revision: 1.0
// ============================================================================
package snn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int c_N_IN     = 8;
  localparam int c_ADDR_W   = 3;
  localparam int c_TICK_DIV = 16;
  localparam int c_CNT_W    = 16;

  // Wide enough for the largest supported neuron bank; callers truncate.
  function automatic logic [63:0] onehot(input int unsigned idx);
    onehot = 64'd1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: lowest request at or above ptr,
//           else lowest request overall.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] grant,
  output logic          any_req
);

  logic [AW-1:0] w_hi_idx;
  logic [AW-1:0] w_lo_idx;
  logic          w_hi_found;

  // Descending scan so the last match written is the lowest index.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = AW'(i);
        if (i >= int'(ptr)) begin
          w_hi_idx   = AW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  assign grant   = w_hi_found ? w_hi_idx : w_lo_idx;
  assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/input_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : input_spike_scheduler
// Brief   : Tick generator and round-robin spike-to-event serialiser for the
//           input neuron bank.
// Revision: 1.0
// ============================================================================
module input_spike_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int N_IN     = c_N_IN,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int TICK_DIV = c_TICK_DIV,
  parameter int CNT_W    = c_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [N_IN-1:0]   spike_in,
  output logic [N_IN-1:0]   ack_out,
  output logic              timer_en,
  output logic              ev_valid,
  output logic [ADDR_W-1:0] ev_addr,
  input  logic              ev_ready,
  output logic [CNT_W-1:0]  ev_count
);

  localparam int                c_PW         = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0]   c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_LAST  = ADDR_W'(N_IN - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;

  logic [c_PW-1:0]   r_presc;
  logic              r_tick;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic              r_valid, w_valid_nx;
  logic [N_IN-1:0]   r_ack, w_ack_nx;
  logic [CNT_W-1:0]  r_count, w_count_nx;

  logic [ADDR_W-1:0] w_grant;
  logic              w_any;

  rr_arbiter #(
    .N  (N_IN),
    .AW (ADDR_W)
  ) u_arb (
    .req     (spike_in),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .any_req (w_any)
  );

  // Prescaler freezes with enable low so tick spacing counts enabled cycles.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= enable && (r_presc == c_PRESC_LAST);
      if (enable)
        r_presc <= (r_presc == c_PRESC_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_ack   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_addr  <= w_addr_nx;
      r_valid <= w_valid_nx;
      r_ack   <= w_ack_nx;
      r_count <= w_count_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_addr_nx  = r_addr;
    w_valid_nx = r_valid;
    w_ack_nx   = '0;
    w_count_nx = r_count;
    case (r_state)
      IDLE: begin
        if (enable && w_any) begin
          w_addr_nx  = w_grant;
          w_valid_nx = 1'b1;
          w_state_nx = SEND;
        end
      end
      SEND: begin
        if (ev_ready) begin
          w_valid_nx = 1'b0;
          w_ack_nx   = N_IN'(onehot(32'(r_addr)));
          w_ptr_nx   = (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
          w_count_nx = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;
          w_state_nx = ACK;
        end
      end
      // The neuron drops its flag on this edge, so IDLE never sees it stale.
      ACK: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  assign ack_out  = r_ack;
  assign timer_en = r_tick;
  assign ev_valid = r_valid;
  assign ev_addr  = r_addr;
  assign ev_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_input_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_spike_scheduler
// Brief   : Directed bench for input_spike_scheduler (default and CNT_W=4).
// Revision: 1.0
// ============================================================================
module tb_input_spike_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [7:0] spike_in;
  logic       ev_ready;

  logic [7:0]  ack_out;
  logic        timer_en;
  logic        ev_valid;
  logic [2:0]  ev_addr;
  logic [15:0] ev_count;

  logic [7:0]  ack_out_s;
  logic        timer_en_s;
  logic        ev_valid_s;
  logic [2:0]  ev_addr_s;
  logic [3:0]  ev_count_s;

  int total = 0;
  int bad   = 0;
  bit auto_clr = 1'b0;

  always #5 clk = ~clk;

  input_spike_scheduler #(.N_IN(8), .ADDR_W(3), .TICK_DIV(16), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable), .spike_in(spike_in),
    .ack_out(ack_out), .timer_en(timer_en), .ev_valid(ev_valid),
    .ev_addr(ev_addr), .ev_ready(ev_ready), .ev_count(ev_count)
  );

  input_spike_scheduler #(.N_IN(8), .ADDR_W(3), .TICK_DIV(16), .CNT_W(4)) u_sat (
    .clk(clk), .resetn(resetn), .enable(enable), .spike_in(spike_in),
    .ack_out(ack_out_s), .timer_en(timer_en_s), .ev_valid(ev_valid_s),
    .ev_addr(ev_addr_s), .ev_ready(ev_ready), .ev_count(ev_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; neurons drop flags on the edge that closes their ack cycle.
  task automatic step();
    logic [7:0] a;
    a = ack_out;
    @(posedge clk);
    #1;
    if (auto_clr) spike_in = spike_in & ~a;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    step();
    resetn = 1'b0;
  endtask

  initial begin
    resetn   = 1'b1;
    enable   = 1'b0;
    spike_in = 8'h00;
    ev_ready = 1'b0;
    repeat (3) step();
    chk("rst_timer_en", 32'(timer_en), 32'd0);
    chk("rst_ack", 32'(ack_out), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_addr", 32'(ev_addr), 32'd0);
    chk("rst_count", 32'(ev_count), 32'd0);
    chk("rst_ptr", 32'(u_dut.r_ptr), 32'd0);
    chk("rst_count_sat", 32'(ev_count_s), 32'd0);

    // Tick spacing, with a 5-cycle enable gap at edges 52..56.
    resetn = 1'b0;
    for (int k = 1; k <= 85; k++) begin
      enable = !(k >= 52 && k <= 56);
      step();
      if (k <= 48) chk($sformatf("tick_%0d", k), 32'(timer_en), 32'(k % 16 == 0));
      else         chk($sformatf("tick_%0d", k), 32'(timer_en), 32'(k == 69 || k == 85));
    end
    enable = 1'b1;

    // Single spike on neuron 2.
    auto_clr = 1'b1;
    ev_ready = 1'b1;
    spike_in = 8'h04;
    step();
    chk("single_valid", 32'(ev_valid), 32'd1);
    chk("single_addr", 32'(ev_addr), 32'd2);
    chk("single_ack_early", 32'(ack_out), 32'd0);
    step();
    chk("single_valid_drop", 32'(ev_valid), 32'd0);
    chk("single_ack", 32'(ack_out), 32'h04);
    chk("single_count", 32'(ev_count), 32'd1);
    chk("single_ptr", 32'(u_dut.r_ptr), 32'd3);
    step();
    chk("single_ack_drop", 32'(ack_out), 32'd0);
    step();
    chk("single_no_reissue", 32'(ev_valid), 32'd0);

    // Round-robin over all flags, twice from pointer 0.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      spike_in = 8'hFF;
      for (int i = 0; i < 8; i++) begin
        step();
        chk($sformatf("rr%0d_valid_%0d", pass, i), 32'(ev_valid), 32'd1);
        chk($sformatf("rr%0d_addr_%0d", pass, i), 32'(ev_addr), 32'(i));
        step();
        chk($sformatf("rr%0d_ack_%0d", pass, i), 32'(ack_out), 32'(8'd1 << i));
        step();
      end
      chk($sformatf("rr%0d_drained", pass), 32'(spike_in), 32'd0);
    end

    // Grants 0..2, then all flags re-raised with pointer at 3.
    spike_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      step();
      step();
    end
    chk("rr_ptr3", 32'(u_dut.r_ptr), 32'd3);
    spike_in = 8'hFF;
    step();
    chk("rr_rearm_addr", 32'(ev_addr), 32'd3);
    step();
    step();
    spike_in = 8'h00;
    step();

    // Backpressure with enable dropped mid-wait.
    do_reset();
    ev_ready = 1'b0;
    spike_in = 8'h81;
    step();
    for (int k = 0; k < 10; k++) begin
      enable = !(k >= 3 && k <= 7);
      step();
      chk($sformatf("bp_valid_%0d", k), 32'(ev_valid), 32'd1);
      chk($sformatf("bp_addr_%0d", k), 32'(ev_addr), 32'd0);
      chk($sformatf("bp_ack_%0d", k), 32'(ack_out), 32'd0);
      chk($sformatf("bp_count_%0d", k), 32'(ev_count), 32'd0);
    end
    enable   = 1'b1;
    ev_ready = 1'b1;
    step();
    chk("bp_ack", 32'(ack_out), 32'h01);
    chk("bp_count", 32'(ev_count), 32'd1);
    step();
    step();
    chk("bp_next_valid", 32'(ev_valid), 32'd1);
    chk("bp_next_addr", 32'(ev_addr), 32'd7);
    step();
    chk("bp_next_ack", 32'(ack_out), 32'h80);
    step();

    // Reset during SEND drops the event; the still-high flag is re-served.
    ev_ready = 1'b0;
    spike_in = 8'h20;
    step();
    chk("rs_valid", 32'(ev_valid), 32'd1);
    chk("rs_addr", 32'(ev_addr), 32'd5);
    step();
    resetn = 1'b1;
    step();
    chk("rs_valid_clr", 32'(ev_valid), 32'd0);
    chk("rs_addr_clr", 32'(ev_addr), 32'd0);
    chk("rs_ack_clr", 32'(ack_out), 32'd0);
    chk("rs_count_clr", 32'(ev_count), 32'd0);
    chk("rs_tick_clr", 32'(timer_en), 32'd0);
    chk("rs_ptr_clr", 32'(u_dut.r_ptr), 32'd0);
    resetn = 1'b0;
    step();
    chk("rs_reissue_valid", 32'(ev_valid), 32'd1);
    chk("rs_reissue_addr", 32'(ev_addr), 32'd5);
    ev_ready = 1'b1;
    step();
    chk("rs_reissue_ack", 32'(ack_out), 32'h20);
    step();

    // enable low in IDLE blocks new grants; pointer 6 wraps to neuron 1.
    enable   = 1'b0;
    spike_in = 8'h02;
    step();
    step();
    chk("en_block", 32'(ev_valid), 32'd0);
    enable = 1'b1;
    step();
    chk("en_grant_valid", 32'(ev_valid), 32'd1);
    chk("en_grant_addr", 32'(ev_addr), 32'd1);
    step();
    chk("en_ack", 32'(ack_out), 32'h02);
    step();

    // Saturation of a 4-bit counter over 20 accepts.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      spike_in = 8'h01;
      step();
      step();
      chk($sformatf("sat_ack_%0d", i), 32'(ack_out_s), 32'h01);
      chk($sformatf("sat_count_%0d", i), 32'(ev_count_s), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
      step();
    end
    chk("sat_final", 32'(ev_count_s), 32'd15);
    chk("wide_count_final", 32'(ev_count), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
